// File: rtl/shift_deserializer.sv
// Serial-to-parallel word assembler with selectable bit order, flush, overrun and ready/valid output.
// Optional even-parity trailer bit is enabled with the SHIFT_DESER_PARITY_EN macro.
module shift_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             sel,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             par_err
);

`ifdef SHIFT_DESER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             lsb_first_q, lsb_first_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             par_err_q, par_err_d;
  logic             order;
  logic             last_bit;
  logic             par_bad;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shreg_q     <= '0;
      out_q       <= '0;
      lsb_first_q <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      out_q       <= out_d;
      lsb_first_q <= lsb_first_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      par_err_q   <= par_err_d;
    end
  end

  always_comb begin
    // Bit order is taken live on the first bit of a word, then held for the rest.
    order    = (state_q == IDLE) ? sel : lsb_first_q;
    shifted  = order ? {ser_in, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], ser_in};
    last_bit = (count_q == CW'(NBITS - 1));
`ifdef SHIFT_DESER_PARITY_EN
    // The final bit is parity; the data bits are already in the assembly register.
    word    = shreg_q;
    par_bad = ^{shreg_q, ser_in};
`else
    word    = shifted;
    par_bad = 1'b0;
`endif

    state_d     = state_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    out_d       = out_q;
    lsb_first_d = lsb_first_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    par_err_d   = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      state_d = IDLE;
      count_d = '0;
      shreg_d = '0;
    end else if (ser_valid) begin
      lsb_first_d = order;
      if (last_bit) begin
        state_d = IDLE;
        count_d = '0;
        shreg_d = '0;
        if (out_valid_q && !out_ready) begin
          overrun_d = 1'b1;
        end else begin
          out_d       = word;
          out_valid_d = 1'b1;
          par_err_d   = par_bad;
        end
      end else begin
        state_d = SHIFT;
        count_d = count_q + 1'b1;
        shreg_d = shifted;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign par_err   = par_err_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer (WIDTH=4); parity scenario runs when SHIFT_DESER_PARITY_EN is defined.
module tb_shift_deserializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       sel = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       overrun;
  logic       par_err;

  int checks = 0;
  int fails = 0;

  shift_deserializer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .sel(sel),
    .flush(flush), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic send_bit(input logic b, input logic s);
    ser_in = b; sel = s; ser_valid = 1'b1;
    @(posedge clk); #1;
    ser_valid = 1'b0;
  endtask

  // Sends bits[3] first; under parity appends the even-parity bit.
  task automatic send_word(input logic [3:0] bits, input logic s, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i], s);
      if (i != 0) repeat (gap) begin @(posedge clk); #1; end
    end
`ifdef SHIFT_DESER_PARITY_EN
    send_bit(^bits, s);
`endif
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out !== 4'b0000) begin fails++; $display("FAIL reset_out: got %b want 0000", out); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (par_err !== 1'b0) begin fails++; $display("FAIL reset_par_err: got %b want 0", par_err); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: out=%b out_valid=%b", out, out_valid);
  endtask

  task automatic test_msb_first();
    send_word(4'b1000, 1'b0, 0);
    checks++; if (out !== 4'b1000) begin fails++; $display("FAIL msb_out: got %b want 1000", out); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL msb_valid: got %b want 1", out_valid); end
    $display("msb_first: out=%b out_valid=%b", out, out_valid);
    consume();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL msb_consume: got %b want 0", out_valid); end
  endtask

  task automatic test_lsb_first();
    send_word(4'b1000, 1'b1, 0);
    checks++; if (out !== 4'b0001) begin fails++; $display("FAIL lsb_out: got %b want 0001", out); end
    $display("lsb_first: out=%b", out);
    consume();
    send_word(4'b0110, 1'b1, 2);
    checks++; if (out !== 4'b0110) begin fails++; $display("FAIL lsb_gap_out: got %b want 0110", out); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lsb_gap_valid: got %b want 1", out_valid); end
    $display("lsb_gaps: out=%b", out);
    consume();
  endtask

  task automatic test_sel_latch();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
`ifdef SHIFT_DESER_PARITY_EN
    send_bit(1'b0, 1'b1);
`endif
    checks++; if (out !== 4'b1100) begin fails++; $display("FAIL sel_latch_out: got %b want 1100", out); end
    $display("sel_latch: out=%b", out);
    consume();
  endtask

  task automatic test_overrun();
    send_word(4'b0110, 1'b0, 0);
    send_word(4'b1111, 1'b0, 0);
    checks++; if (out !== 4'b0110) begin fails++; $display("FAIL ovr_keep_out: got %b want 0110", out); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
    @(posedge clk); #1;
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_single: got %b want 0", overrun); end
    // Next word completes on the same edge the held word is accepted.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
`ifdef SHIFT_DESER_PARITY_EN
    send_bit(1'b0, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
`else
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
`endif
    out_ready = 1'b0;
    checks++; if (out !== 4'b1010) begin fails++; $display("FAIL ovr_coincide_out: got %b want 1010", out); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ovr_coincide_valid: got %b want 1", out_valid); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_coincide_pulse: got %b want 0", overrun); end
    $display("overrun: out=%b out_valid=%b overrun=%b", out, out_valid, overrun);
    consume();
  endtask

  task automatic test_flush();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    flush = 1'b1; ser_in = 1'b1; ser_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; ser_valid = 1'b0;
    send_word(4'b1011, 1'b0, 0);
    checks++; if (out !== 4'b1011) begin fails++; $display("FAIL flush_out: got %b want 1011", out); end
    $display("flush: out=%b", out);
  endtask

  task automatic test_reset_mid();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++; if (out !== 4'b0000) begin fails++; $display("FAIL rmid_out: got %b want 0000", out); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_bit(1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_fresh_valid: got %b want 0", out_valid); end
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
`ifdef SHIFT_DESER_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    checks++; if (out !== 4'b0101) begin fails++; $display("FAIL rmid_fresh_out: got %b want 0101", out); end
    $display("reset_mid: out=%b", out);
    consume();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_word(4'b1001, 1'b0, 0);
    checks++; if (out !== 4'b1001 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_first: got %b/%b want 1001/1", out, out_valid); end
    send_word(4'b0111, 1'b0, 0);
    checks++; if (out !== 4'b0111 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_second: got %b/%b want 0111/1", out, out_valid); end
    $display("back_to_back: out=%b", out);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_parity();
`ifdef SHIFT_DESER_PARITY_EN
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    checks++; if (out !== 4'b0110) begin fails++; $display("FAIL par_bad_out: got %b want 0110", out); end
    checks++; if (par_err !== 1'b1) begin fails++; $display("FAIL par_bad_flag: got %b want 1", par_err); end
    consume();
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    checks++; if (par_err !== 1'b0) begin fails++; $display("FAIL par_good_flag: got %b want 0", par_err); end
    $display("parity: out=%b par_err=%b", out, par_err);
    consume();
`endif
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_sel_latch();
    test_overrun();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port ser_in, input, 1 bit: serial data bit.
REQ-005 SHALL have port ser_valid, input, 1 bit: ser_in is sampled on this edge.
REQ-006 SHALL have port sel, input, 1 bit: bit order, 0 = MSB-first, 1 = LSB-first.
REQ-007 SHALL have port flush, input, 1 bit: synchronous abort of the partial word.
REQ-008 SHALL have port out, output, WIDTH bits: assembled word.
REQ-009 SHALL have port out_valid, output, 1 bit: out holds an unconsumed word.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out when out_valid=1.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed word is dropped.
REQ-012 SHALL have port par_err, output, 1 bit: one-cycle parity-error pulse (see Configuration).

Function
REQ-013 SHALL implement a two-state FSM, IDLE (bit count 0) and SHIFT (count 1..N-1), where N = WIDTH, or WIDTH+1 when parity is enabled.
REQ-014 SHALL, on the first accepted bit of a word, latch sel and apply it to the whole word; sel changes mid-word have no effect.
REQ-015 SHALL, for MSB-first, shift the assembly register logically left by 1 with ser_in entering bit 0.
REQ-016 SHALL, for LSB-first, shift the assembly register logically right by 1 with ser_in entering bit WIDTH-1.
REQ-017 SHALL count accepted bits modulo N; cycles with ser_valid=0 leave all shift state unchanged.
REQ-018 SHALL, on the edge that accepts bit N, transfer the word to out and set out_valid=1 at that edge, so the word is visible the following cycle; the count wraps to 0 and the FSM returns to IDLE.
REQ-019 SHALL hold out and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL clear out_valid on an edge with out_valid=1 and out_ready=1, unless a new word completes on that same edge.
REQ-021 SHALL, if a word completes on the same edge that out_ready=1 accepts the held word, load the new word and keep out_valid=1 without pulsing overrun.
REQ-022 SHALL, if a word completes while out_valid=1 and out_ready=0, drop the new word, keep the old one, and pulse overrun for one cycle.
REQ-023 SHALL, when flush=1, zero the count and the assembly register and return to IDLE, ignoring ser_valid on that edge; out and out_valid are unaffected.
REQ-024 SHALL support back-to-back words with no idle cycle between the last bit of one word and the first bit of the next.

Reset
REQ-025 SHALL, while rst_n=0, immediately force: FSM=IDLE, count=0, assembly register=0, out=0, out_valid=0, overrun=0, par_err=0.
REQ-026 SHALL, on reset asserted mid-word, discard the partial word; the first ser_valid after release starts a new word.

Configuration
REQ-027 SHALL, with macro SHIFT_DESER_PARITY_EN defined, treat each word as WIDTH data bits followed by one even-parity bit that is not stored in out.
REQ-028 SHALL, with SHIFT_DESER_PARITY_EN defined, pulse par_err for one cycle, aligned with the out_valid update, when the XOR of data and parity bit is 1; the word is still delivered.
REQ-029 SHALL, without SHIFT_DESER_PARITY_EN, use N = WIDTH and tie par_err to 0.

Verification (WIDTH=4, parity off unless stated)
REQ-030 SHALL cover: sel=0, bits 1,0,0,0 on consecutive cycles -> out=4'b1000, out_valid=1 the cycle after the 4th bit.
REQ-031 SHALL cover: sel=1, bits 1,0,0,0 -> out=4'b0001; bits 0,1,1,0 with gaps of ser_valid=0 -> out=4'b0110.
REQ-032 SHALL cover: out_ready=0 held through two complete words 0110 then 1111 -> out stays 4'b0110 and overrun pulses once; the out_ready=1 edge coinciding with the next completion loads it without overrun.
REQ-033 SHALL cover: flush after 2 bits, then bits 1,0,1,1 MSB-first -> out=4'b1011.
REQ-034 SHALL cover: rst_n pulsed low after 3 bits -> all outputs 0 immediately; the next 4 bits form a fresh word.
REQ-035 SHALL cover, with SHIFT_DESER_PARITY_EN: data 0110 with parity 1 -> out=4'b0110 and par_err=1; with parity 0 -> par_err=0.
